// File: rtl/colour_bbox_tracker.sv
// colour_bbox_tracker
//   Per-frame blob extractor downstream of the pixel classifier. It tracks
//   the pixel coordinate, applies a horizontal run-length noise filter, and
//   accumulates a bounding box and qualified-pixel count for each of the
//   five ball colours (classes 1..5). At end of frame the accumulators are
//   copied into a readout bank.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   in_valid            pixel strobe; every other pixel input is ignored when low
//   in_sop/eol/eop      frame start / line end / frame end markers
//   class_in            colour class aligned with the markers (6,7 read as 0)
//   rd_sel              readout class select (1..5; others read zero)
//   rd_min/max_x/y      committed bounding box for rd_sel (combinational)
//   rd_count            committed qualified pixel count for rd_sel
//   found               bit c-1 set when class c reached MIN_PIXELS last frame
//   frame_done          one-cycle pulse in the cycle the bank is loaded
//   frame_cnt           committed frame counter, wraps 255 -> 0
module colour_bbox_tracker #(
  parameter int MIN_RUN    = 4,
  parameter int MIN_PIXELS = 64,
  parameter int X_W        = 11,
  parameter int Y_W        = 11,
  parameter int CNT_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eol,
  input  logic             in_eop,
  input  logic [2:0]       class_in,
  input  logic [2:0]       rd_sel,
  output logic [X_W-1:0]   rd_min_x,
  output logic [X_W-1:0]   rd_max_x,
  output logic [Y_W-1:0]   rd_min_y,
  output logic [Y_W-1:0]   rd_max_y,
  output logic [CNT_W-1:0] rd_count,
  output logic [4:0]       found,
  output logic             frame_done,
  output logic [7:0]       frame_cnt
);

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MIN_RUN);
  localparam logic [CNT_W-1:0] PIX_THR = CNT_W'(MIN_PIXELS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic [RUN_W-1:0]        run_q, run_d;
  logic [2:0]              prev_cls_q, prev_cls_d;
  logic                    commit_q, commit_d;

  logic [4:0][X_W-1:0]     acc_min_x_q, acc_min_x_d, acc_max_x_q, acc_max_x_d;
  logic [4:0][Y_W-1:0]     acc_min_y_q, acc_min_y_d, acc_max_y_q, acc_max_y_d;
  logic [4:0][CNT_W-1:0]   acc_cnt_q, acc_cnt_d;

  logic [4:0][X_W-1:0]     bank_min_x_q, bank_min_x_d, bank_max_x_q, bank_max_x_d;
  logic [4:0][Y_W-1:0]     bank_min_y_q, bank_min_y_d, bank_max_y_q, bank_max_y_d;
  logic [4:0][CNT_W-1:0]   bank_cnt_q, bank_cnt_d;
  logic [4:0]              found_q, found_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;

  logic                    take;
  logic                    first_px;
  logic                    qualify;
  logic [2:0]              cls;
  logic [X_W-1:0]          px;
  logic [Y_W-1:0]          py;
  logic [RUN_W-1:0]        run_len;
  logic                    sel_ok;
  logic [2:0]              rd_idx;

  // Current pixel decode: coordinate, run length and qualification.
  always_comb begin
    cls  = (class_in > 3'd5) ? 3'd0 : class_in;
    // In IDLE only a sop pixel is accepted; it starts a frame.
    take = in_valid & (in_sop | (state_q == ST_ACTIVE));
    px   = in_sop ? '0 : x_q;
    py   = in_sop ? '0 : y_q;
    // x only returns to 0 at the start of a line (sop or after eol).
    first_px = (px == '0);
    if (cls == 3'd0) begin
      run_len = '0;
    end else if (first_px || (cls != prev_cls_q)) begin
      run_len = RUN_W'(1);
    end else if (run_q >= RUN_SAT) begin
      run_len = RUN_SAT;
    end else begin
      run_len = run_q + RUN_W'(1);
    end
    qualify = take & (cls != 3'd0) & (run_len >= RUN_SAT);
  end

  // Next-state for FSM, coordinate tracker and per-class accumulators.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    run_d       = run_q;
    prev_cls_d  = prev_cls_q;
    commit_d    = 1'b0;
    acc_min_x_d = acc_min_x_q;
    acc_max_x_d = acc_max_x_q;
    acc_min_y_d = acc_min_y_q;
    acc_max_y_d = acc_max_y_q;
    acc_cnt_d   = acc_cnt_q;
    if (take) begin
      state_d    = in_eop ? ST_IDLE : ST_ACTIVE;
      commit_d   = in_eop;
      run_d      = run_len;
      prev_cls_d = cls;
      if (in_eol) begin
        x_d = '0;
        y_d = (py == '1) ? py : py + Y_W'(1);
      end else begin
        x_d = (px == '1) ? px : px + X_W'(1);
        y_d = py;
      end
      // A sop pixel is processed against freshly cleared accumulators.
      if (in_sop) begin
        acc_min_x_d = '1;
        acc_max_x_d = '0;
        acc_min_y_d = '1;
        acc_max_y_d = '0;
        acc_cnt_d   = '0;
      end else begin
        acc_cnt_d   = acc_cnt_q;
      end
      for (int c = 0; c < 5; c++) begin
        if (qualify && (cls == 3'(c + 1))) begin
          acc_min_x_d[c] = (px < acc_min_x_d[c]) ? px : acc_min_x_d[c];
          acc_max_x_d[c] = (px > acc_max_x_d[c]) ? px : acc_max_x_d[c];
          acc_min_y_d[c] = (py < acc_min_y_d[c]) ? py : acc_min_y_d[c];
          acc_max_y_d[c] = (py > acc_max_y_d[c]) ? py : acc_max_y_d[c];
          acc_cnt_d[c]   = (acc_cnt_d[c] == '1) ? acc_cnt_d[c]
                                                : acc_cnt_d[c] + CNT_W'(1);
        end else begin
          acc_cnt_d[c]   = acc_cnt_d[c];
        end
      end
    end else begin
      commit_d = 1'b0;
    end
  end

  // Bank load one cycle after the eop pixel has reached the accumulators.
  always_comb begin
    bank_min_x_d = bank_min_x_q;
    bank_max_x_d = bank_max_x_q;
    bank_min_y_d = bank_min_y_q;
    bank_max_y_d = bank_max_y_q;
    bank_cnt_d   = bank_cnt_q;
    found_d      = found_q;
    frame_cnt_d  = frame_cnt_q;
    if (commit_q) begin
      bank_min_x_d = acc_min_x_q;
      bank_max_x_d = acc_max_x_q;
      bank_min_y_d = acc_min_y_q;
      bank_max_y_d = acc_max_y_q;
      bank_cnt_d   = acc_cnt_q;
      for (int c = 0; c < 5; c++) begin
        found_d[c] = (acc_cnt_q[c] >= PIX_THR);
      end
      frame_cnt_d  = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d  = frame_cnt_q;
    end
  end

  // All state; reset discards any frame in progress and zeroes the bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      run_q        <= '0;
      prev_cls_q   <= 3'd0;
      commit_q     <= 1'b0;
      acc_min_x_q  <= '1;
      acc_max_x_q  <= '0;
      acc_min_y_q  <= '1;
      acc_max_y_q  <= '0;
      acc_cnt_q    <= '0;
      bank_min_x_q <= '0;
      bank_max_x_q <= '0;
      bank_min_y_q <= '0;
      bank_max_y_q <= '0;
      bank_cnt_q   <= '0;
      found_q      <= 5'd0;
      frame_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      run_q        <= run_d;
      prev_cls_q   <= prev_cls_d;
      commit_q     <= commit_d;
      acc_min_x_q  <= acc_min_x_d;
      acc_max_x_q  <= acc_max_x_d;
      acc_min_y_q  <= acc_min_y_d;
      acc_max_y_q  <= acc_max_y_d;
      acc_cnt_q    <= acc_cnt_d;
      bank_min_x_q <= bank_min_x_d;
      bank_max_x_q <= bank_max_x_d;
      bank_min_y_q <= bank_min_y_d;
      bank_max_y_q <= bank_max_y_d;
      bank_cnt_q   <= bank_cnt_d;
      found_q      <= found_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Combinational readout; empty classes and invalid selects read zero.
  always_comb begin
    sel_ok = 1'b1;
    case (rd_sel)
      3'd1:    rd_idx = 3'd0;
      3'd2:    rd_idx = 3'd1;
      3'd3:    rd_idx = 3'd2;
      3'd4:    rd_idx = 3'd3;
      3'd5:    rd_idx = 3'd4;
      default: begin
        rd_idx = 3'd0;
        sel_ok = 1'b0;
      end
    endcase
    if (sel_ok && (bank_cnt_q[rd_idx] != '0)) begin
      rd_min_x = bank_min_x_q[rd_idx];
      rd_max_x = bank_max_x_q[rd_idx];
      rd_min_y = bank_min_y_q[rd_idx];
      rd_max_y = bank_max_y_q[rd_idx];
      rd_count = bank_cnt_q[rd_idx];
    end else begin
      rd_min_x = '0;
      rd_max_x = '0;
      rd_min_y = '0;
      rd_max_y = '0;
      rd_count = '0;
    end
  end

  assign found      = found_q;
  assign frame_done = commit_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_colour_bbox_tracker.sv
// Testbench for colour_bbox_tracker. Two instances share one stimulus
// stream: u0 with MIN_RUN=4, MIN_PIXELS=1 and full widths, u1 with
// MIN_RUN=1, MIN_PIXELS=3 and narrow widths so coordinate and count
// saturation are reachable. A frame-level model recomputes each bank from
// the recorded pixel list of the frame.
module tb_colour_bbox_tracker;

  localparam int MR0 = 4;
  localparam int MP0 = 1;
  localparam int MR1 = 1;
  localparam int MP1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_sop, in_eol, in_eop;
  logic [2:0] class_in, rd_sel;

  logic [10:0] a_min_x, a_max_x, a_min_y, a_max_y;
  logic [19:0] a_cnt;
  logic [4:0]  a_found;
  logic        a_fd;
  logic [7:0]  a_fc;
  logic [2:0]  b_min_x, b_max_x;
  logic [1:0]  b_min_y, b_max_y;
  logic [3:0]  b_cnt;
  logic [4:0]  b_found;
  logic        b_fd;
  logic [7:0]  b_fc;

  colour_bbox_tracker #(.MIN_RUN(MR0), .MIN_PIXELS(MP0), .X_W(11), .Y_W(11), .CNT_W(20)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eol(in_eol),
    .in_eop(in_eop), .class_in(class_in), .rd_sel(rd_sel),
    .rd_min_x(a_min_x), .rd_max_x(a_max_x), .rd_min_y(a_min_y), .rd_max_y(a_max_y),
    .rd_count(a_cnt), .found(a_found), .frame_done(a_fd), .frame_cnt(a_fc));

  colour_bbox_tracker #(.MIN_RUN(MR1), .MIN_PIXELS(MP1), .X_W(3), .Y_W(2), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eol(in_eol),
    .in_eop(in_eop), .class_in(class_in), .rd_sel(rd_sel),
    .rd_min_x(b_min_x), .rd_max_x(b_max_x), .rd_min_y(b_min_y), .rd_max_y(b_max_y),
    .rd_count(b_cnt), .found(b_found), .frame_done(b_fd), .frame_cnt(b_fc));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int fd0 = 0;
  int fd1 = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int bk_minx[2][5], bk_maxx[2][5], bk_miny[2][5], bk_maxy[2][5], bk_cnt[2][5];
  int nb_minx[2][5], nb_maxx[2][5], nb_miny[2][5], nb_maxy[2][5], nb_cnt[2][5];
  int fcnt = 0;
  bit pend = 1'b0;
  bit infr = 1'b0;
  int flen = 0;
  int fcls[512];
  bit feol[512];

  // Recompute a class summary from the whole pixel list of the frame.
  // A pixel qualifies when it and the MIN_RUN-1 pixels before it have the
  // same nonzero class with no line end in between.
  task automatic compute_bank(input int i);
    int x, y, mr, xmax, ymax, cmax, c, q;
    mr   = (i == 0) ? MR0 : MR1;
    xmax = (i == 0) ? 2047 : 7;
    ymax = (i == 0) ? 2047 : 3;
    cmax = (i == 0) ? 1048575 : 15;
    for (int k = 0; k < 5; k++) begin
      nb_cnt[i][k] = 0; nb_minx[i][k] = 1 << 24; nb_maxx[i][k] = 0;
      nb_miny[i][k] = 1 << 24; nb_maxy[i][k] = 0;
    end
    x = 0; y = 0;
    for (int k = 0; k < flen; k++) begin
      c = fcls[k];
      q = (c != 0 && k >= mr - 1) ? 1 : 0;
      if (q == 1) begin
        for (int j = 1; j < mr; j++)
          if (fcls[k-j] != c || feol[k-j]) q = 0;
      end
      if (q == 1) begin
        if (x < nb_minx[i][c-1]) nb_minx[i][c-1] = x;
        if (x > nb_maxx[i][c-1]) nb_maxx[i][c-1] = x;
        if (y < nb_miny[i][c-1]) nb_miny[i][c-1] = y;
        if (y > nb_maxy[i][c-1]) nb_maxy[i][c-1] = y;
        if (nb_cnt[i][c-1] < cmax) nb_cnt[i][c-1]++;
      end
      if (feol[k]) begin
        x = 0;
        y = (y < ymax) ? y + 1 : ymax;
      end else begin
        x = (x < xmax) ? x + 1 : xmax;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 5; c++) begin
          bk_minx[i][c] = 0; bk_maxx[i][c] = 0; bk_miny[i][c] = 0;
          bk_maxy[i][c] = 0; bk_cnt[i][c] = 0;
        end
      fcnt = 0; pend = 1'b0; infr = 1'b0; flen = 0;
    end else begin
      if (pend) begin
        for (int i = 0; i < 2; i++)
          for (int c = 0; c < 5; c++) begin
            bk_minx[i][c] = nb_minx[i][c]; bk_maxx[i][c] = nb_maxx[i][c];
            bk_miny[i][c] = nb_miny[i][c]; bk_maxy[i][c] = nb_maxy[i][c];
            bk_cnt[i][c]  = nb_cnt[i][c];
          end
        fcnt = (fcnt + 1) % 256;
        pend = 1'b0;
      end
      if (in_valid && (in_sop || infr)) begin
        if (in_sop) flen = 0;
        if (flen < 512) begin
          fcls[flen] = (class_in > 3'd5) ? 0 : int'(class_in);
          feol[flen] = in_eol;
          flen++;
        end
        if (in_eop) begin
          compute_bank(0);
          compute_bank(1);
          pend = 1'b1;
          infr = 1'b0;
        end else begin
          infr = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int s, ef, mp;
    int e[5];
    int a[5];
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        s  = int'(rd_sel);
        mp = (i == 0) ? MP0 : MP1;
        if (s >= 1 && s <= 5 && bk_cnt[i][s-1] > 0) begin
          e[0] = bk_minx[i][s-1]; e[1] = bk_maxx[i][s-1]; e[2] = bk_miny[i][s-1];
          e[3] = bk_maxy[i][s-1]; e[4] = bk_cnt[i][s-1];
        end else begin
          for (int k = 0; k < 5; k++) e[k] = 0;
        end
        ef = 0;
        for (int c = 0; c < 5; c++) if (bk_cnt[i][c] >= mp) ef = ef | (1 << c);
        if (i == 0) begin
          a[0] = int'(a_min_x); a[1] = int'(a_max_x); a[2] = int'(a_min_y);
          a[3] = int'(a_max_y); a[4] = int'(a_cnt);
          chk("u0.frame_done", int'(a_fd), int'(pend));
          chk("u0.frame_cnt", int'(a_fc), fcnt);
          chk("u0.found", int'(a_found), ef);
        end else begin
          a[0] = int'(b_min_x); a[1] = int'(b_max_x); a[2] = int'(b_min_y);
          a[3] = int'(b_max_y); a[4] = int'(b_cnt);
          chk("u1.frame_done", int'(b_fd), int'(pend));
          chk("u1.frame_cnt", int'(b_fc), fcnt);
          chk("u1.found", int'(b_found), ef);
        end
        chk($sformatf("u%0d.rd_min_x", i), a[0], e[0]);
        chk($sformatf("u%0d.rd_max_x", i), a[1], e[1]);
        chk($sformatf("u%0d.rd_min_y", i), a[2], e[2]);
        chk($sformatf("u%0d.rd_max_y", i), a[3], e[3]);
        chk($sformatf("u%0d.rd_count", i), a[4], e[4]);
      end
    end
  end

  always @(negedge clk) begin
    if (a_fd) fd0++;
    if (b_fd) fd1++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit s, input bit l, input bit e, input int c);
    in_valid = v; in_sop = s; in_eol = l; in_eop = e;
    class_in = 3'(c);
    rd_sel   = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
  endtask

  function automatic int pat_cls(input int pat, input int x, input int y, input int prev);
    case (pat)
      1: return ((y == 1 || y == 2) && x >= 2) ? 3 : 0;
      2: return (x % 2 == 0) ? 1 : 0;
      3: return (x >= 2 && x <= 5) ? 1 : 0;
      4: return ((y == 0 && x >= 6) || (y == 1 && x <= 1)) ? 2 : 0;
      5: return 1;
      9: return ($urandom_range(0, 99) < 70) ? prev : int'($urandom_range(0, 7));
      default: return 0;
    endcase
  endfunction

  task automatic send_frame(input int w, input int h, input int pat, input int gap_pct,
                            input int abort_at, input int stop_after);
    int k, lc, c;
    k = 0; lc = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        c = pat_cls(pat, x, y, lc);
        lc = c;
        if (stop_after < 0 || k < stop_after) begin
          if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct)
            idle(int'($urandom_range(1, 3)));
          drive(1'b1, (k == 0) || (k == abort_at), x == w - 1,
                (x == w - 1) && (y == h - 1), c);
        end
        k++;
      end
  endtask

  task automatic lit(input int sel, input string tag, input int u, input int mnx,
                     input int mxx, input int mny, input int mxy, input int cnt);
    rd_sel = 3'(sel);
    #1;
    if (u == 0) begin
      chk({tag, ".u0.min_x"}, int'(a_min_x), mnx);
      chk({tag, ".u0.max_x"}, int'(a_max_x), mxx);
      chk({tag, ".u0.min_y"}, int'(a_min_y), mny);
      chk({tag, ".u0.max_y"}, int'(a_max_y), mxy);
      chk({tag, ".u0.count"}, int'(a_cnt), cnt);
    end else begin
      chk({tag, ".u1.min_x"}, int'(b_min_x), mnx);
      chk({tag, ".u1.max_x"}, int'(b_max_x), mxx);
      chk({tag, ".u1.min_y"}, int'(b_min_y), mny);
      chk({tag, ".u1.max_y"}, int'(b_max_y), mxy);
      chk({tag, ".u1.count"}, int'(b_cnt), cnt);
    end
    chk({tag, ".model_count"}, bk_cnt[u][sel-1], cnt);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
  endtask

  initial begin
    int fdb, w, h, ab, st;
    rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eol = 1'b0; in_eop = 1'b0;
    class_in = 3'd0; rd_sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rd_sel = 3'd3;
    #1;
    chk("reset.frame_cnt", int'(a_fc), 0);
    chk("reset.found", int'(a_found), 0);
    chk("reset.frame_done", int'(a_fd), 0);
    chk("reset.count", int'(a_cnt), 0);
    chk("reset.u1.frame_cnt", int'(b_fc), 0);
    rst = 1'b1;
    idle(2);

    // 8x4 frame, green block, frame_done timing
    send_frame(8, 4, 1, 0, -1, -1);
    chk("t1.frame_done_cycle_after_eop", int'(a_fd), 1);
    idle(1);
    chk("t1.frame_done_one_cycle", int'(a_fd), 0);
    lit(3, "t1", 0, 5, 7, 1, 2, 6);
    chk("t1.found", int'(a_found), 5'b00100);
    chk("t1.frame_cnt", int'(a_fc), 1);

    // half frame leaves the bank alone
    send_frame(8, 4, 5, 10, -1, 16);
    lit(3, "hold", 0, 5, 7, 1, 2, 6);
    chk("hold.frame_cnt", int'(a_fc), 1);

    // reset mid-frame
    rst = 1'b0;
    rd_sel = 3'd3;
    #1;
    chk("midrst.frame_cnt", int'(a_fc), 0);
    chk("midrst.found", int'(a_found), 0);
    chk("midrst.count", int'(a_cnt), 0);
    chk("midrst.u1.count", int'(b_cnt), 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    send_frame(8, 4, 1, 30, -1, -1);
    idle(2);
    lit(3, "after_rst", 0, 5, 7, 1, 2, 6);
    chk("after_rst.frame_cnt", int'(a_fc), 1);

    // run filter
    send_frame(8, 1, 2, 0, -1, -1);
    idle(2);
    lit(1, "alt", 0, 0, 0, 0, 0, 0);
    chk("alt.found0", int'(a_found[0]), 0);
    lit(1, "alt", 1, 0, 6, 0, 0, 4);
    send_frame(8, 1, 3, 0, -1, -1);
    idle(2);
    lit(1, "run4", 0, 5, 5, 0, 0, 1);

    // run broken by eol
    send_frame(8, 2, 4, 0, -1, -1);
    idle(2);
    lit(2, "eolbrk", 0, 0, 0, 0, 0, 0);
    lit(2, "eolbrk", 1, 0, 7, 0, 1, 4);

    // abort by sop while active
    pulse_reset();
    fdb = fd0;
    for (int k = 0; k < 20; k++) drive(1'b1, k == 0, 1'b0, 1'b0, 4);
    for (int k = 0; k < 8; k++) drive(1'b1, k == 0, 1'b0, k == 7, 0);
    idle(3);
    lit(4, "abort", 0, 0, 0, 0, 0, 0);
    lit(4, "abort", 1, 0, 0, 0, 0, 0);
    chk("abort.frame_done_pulses", fd0 - fdb, 1);
    chk("abort.frame_cnt", int'(a_fc), 1);

    // coordinate and count saturation on the narrow instance
    send_frame(12, 5, 5, 0, -1, -1);
    idle(2);
    lit(1, "sat", 0, 3, 11, 0, 4, 45);
    lit(1, "sat", 1, 0, 7, 0, 3, 15);
    chk("sat.u1.found0", int'(b_found[0]), 1);

    // single-pixel frame
    fdb = fd1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5);
    idle(3);
    lit(5, "single", 1, 0, 0, 0, 0, 1);
    lit(5, "single", 0, 0, 0, 0, 0, 0);
    chk("single.frame_done_pulses", fd1 - fdb, 1);
    chk("single.u1.found4", int'(b_found[4]), 0);

    // randomized frames: gaps, aborts, truncation, stray pixels, back-to-back
    repeat (40) begin
      w  = int'($urandom_range(1, 12));
      h  = int'($urandom_range(1, 5));
      ab = (w * h > 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, w * h - 1)) : -1;
      st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, w * h)) : -1;
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 4))
          drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)));
      send_frame(w, h, 9, int'($urandom_range(0, 30)), ab, st);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
    end

    // frame counter wrap with back-to-back single-pixel frames
    repeat (260) begin
      drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/colour_bbox_tracker.md
# colour_bbox_tracker

Per-frame blob extractor placed directly downstream of the pixel classifier. It consumes one 3-bit colour class per pixel (0 = unclassified, 1 = red, 2 = yellow, 3 = green, 4 = blue, 5 = pink) together with frame and line markers. It tracks the pixel coordinate, applies a horizontal run-length noise filter, and accumulates a bounding box and pixel count for each of the five ball colours. Results are committed to a readout bank at end of frame for the rover navigation logic.

## Interface
- MIN_RUN, 4: consecutive same-class pixels on a line before a pixel qualifies (1..15)
- MIN_PIXELS, 64: qualified pixel count at or above which a class is flagged found
- X_W, 11: x coordinate width
- Y_W, 11: y coordinate width
- CNT_W, 20: per-class pixel counter width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel strobe; all pixel inputs ignored when low
- in_sop  in  1  first pixel of frame, qualified by in_valid
- in_eol  in  1  last pixel of line, qualified by in_valid
- in_eop  in  1  last pixel of frame, qualified by in_valid
- class_in  in  3  classifier output; must be aligned with the markers, so upstream delays the markers by the classifier's 2-cycle latency
- rd_sel  in  3  readout class select (1..5)
- rd_min_x / rd_max_x  out  X_W  committed box x bounds for rd_sel
- rd_min_y / rd_max_y  out  Y_W  committed box y bounds for rd_sel
- rd_count  out  CNT_W  committed qualified pixel count for rd_sel
- found  out  5  bit c-1 set when class c count >= MIN_PIXELS in last committed frame
- frame_done  out  1  one-cycle pulse when the bank updates
- frame_cnt  out  8  committed frames, wraps 255→0

## Operation
- FSM states:
  - IDLE: waits for in_valid & in_sop; all other pixels are ignored.
  - ACTIVE: accumulates pixels until in_valid & in_eop, then commits and returns to IDLE.
- Coordinates:
  - The sop pixel has x=0, y=0.
  - Each valid pixel increments x, which saturates at 2^X_W−1.
  - The pixel after an eol pixel has x=0 and y+1; y saturates at 2^Y_W−1.
- Run filter:
  - run_len counts the current pixel's run of identical nonzero class on the current line, saturating at MIN_RUN.
  - Class 0, a class change, or the first pixel after eol or sop restarts the run at 1 (or 0 for class 0).
  - A pixel qualifies when run_len including itself >= MIN_RUN.
  - Earlier pixels of the run are not counted retroactively.
- Accumulation for a qualified pixel of class c: min_x = min(min_x, x), max_x = max(max_x, x), likewise for y, count += 1 (count saturates at 2^CNT_W−1).
- Classes 6 and 7 are treated as 0.
- Frame start: the sop pixel clears all accumulators (min = all ones, max = 0, count = 0) and is itself processed against the cleared state.
- sop while ACTIVE: the current frame is abandoned without commit and restarted. There is no frame_done.
- sop and eop on the same pixel: the frame is one pixel long; clear, process, and commit in that order.
- Commit: the bank copies all accumulators, found is recomputed, and frame_cnt increments.
- Readout values:
  - A class with count 0 reads min/max as 0.
  - rd_sel of 0, 6 or 7 reads all zeros.
- Reset values:
  - All outputs 0; bank zeroed; FSM in IDLE; accumulators cleared.
  - Reset mid-frame discards the frame.

## Timing
- Accumulators are registered: pixel at cycle t affects state at t+1.
- eop pixel at cycle t: the bank, found and frame_cnt update at the edge ending t+1, including pixel t. frame_done is high during cycle t+1 only.
- rd_* are combinational from the bank and rd_sel, so they are valid in the same cycle rd_sel changes.
- The bank is stable between frame_done pulses; accumulation of the next frame never disturbs it.
- in_valid gaps of any length are allowed anywhere; x/y and run_len advance only on valid pixels.
- Back-to-back frames: a sop on the cycle after eop is accepted.

## Test plan
- 8x4 frame, MIN_RUN=4, MIN_PIXELS=1; class 3 at x=2..7 on rows 1–2 → green box x 5..7, y 1..2, count 6, found=00100, frame_done one cycle after eop, frame_cnt=1.
- Run filter: a row of class 1 with alternating 1,0 every pixel → red count 0, found[0]=0. A run of exactly 4 red pixels → count 1, min_x = max_x = run start+3.
- Run broken by eol: class 2 at x=6,7 of row 0 and x=0,1 of row 1 (width 8) → count 0.
- Abort: sop, 20 pixels of class 4, sop again, 8 pixels of class 0, eop → blue count 0, exactly one frame_done, frame_cnt=1.
- Hold and reset: after a committed frame, stream a half frame → bank unchanged. Assert rst mid-frame → all outputs 0; the next full frame commits normally.
- Single-pixel frame (sop=eop=1, class 5, MIN_RUN=1) → pink box 0,0..0,0, count 1, frame_done pulse.
